// File: rtl/wash_phase_timer.sv
// Phase timer for the wash sequencer: counts minutes inside the current phase
// and emits registered minute strobes; clears on phase change, freezes on pause.
module wash_phase_timer #(
   parameter int unsigned BASE_CYCLES = 60000000,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MIN_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       clk_freq,
   input  logic [2:0]       phase,
   input  logic             pause,
   output logic             minute_tick,
   output logic             minutes_1,
   output logic             minutes_2,
   output logic             minutes_5,
   output logic [MIN_W-1:0] elapsed_min
);

   localparam logic [2:0]       PH_IDLE = 3'b000;
   localparam logic [MIN_W-1:0] MIN_MAX = {MIN_W{1'b1}};

   logic [2:0]       prev_phase;
   logic             phase_chg;
   logic             phase_run;

   logic [CNT_W-1:0] base_t;
   logic [CNT_W-1:0] period_t;
   logic [CNT_W-1:0] period_m1;
   logic             terminal;

   logic [CNT_W-1:0] prescaler;
   logic [CNT_W-1:0] prescaler_nxt;
   logic [MIN_W-1:0] elapsed_q;
   logic [MIN_W-1:0] elapsed_nxt;
   logic [MIN_W-1:0] elapsed_inc;
   logic             at_max;

   logic             tick_q, tick_nxt;
   logic             m1_q, m1_nxt;
   logic             m2_q, m2_nxt;
   logic             m5_q, m5_nxt;

   assign phase_chg = (phase != prev_phase);

   always_comb begin
      phase_run = 1'b0;
      unique case (phase)
         3'b001, 3'b010, 3'b011, 3'b100: phase_run = 1'b1;
         default:                        phase_run = 1'b0;
      endcase
   end

   // period re-evaluated every cycle so a clk_freq change lands immediately
   assign base_t    = CNT_W'(BASE_CYCLES);
   assign period_t  = base_t << clk_freq;
   assign period_m1 = period_t - CNT_W'(1);
   assign terminal  = (prescaler >= period_m1);

   assign at_max      = (elapsed_q == MIN_MAX);
   assign elapsed_inc = at_max ? elapsed_q : elapsed_q + MIN_W'(1);

   always_comb begin
      prescaler_nxt = prescaler;
      elapsed_nxt   = elapsed_q;
      tick_nxt      = 1'b0;
      m1_nxt        = 1'b0;
      m2_nxt        = 1'b0;
      m5_nxt        = 1'b0;
      if (phase_chg) begin
         prescaler_nxt = '0;
         elapsed_nxt   = '0;
      end else if (!phase_run) begin
         prescaler_nxt = '0;
         elapsed_nxt   = '0;
      end else if (pause) begin
         prescaler_nxt = prescaler;
         elapsed_nxt   = elapsed_q;
      end else if (terminal) begin
         prescaler_nxt = '0;
         elapsed_nxt   = elapsed_inc;
         tick_nxt      = 1'b1;
         // saturated count never re-arms the per-minute strobes
         m1_nxt        = !at_max && (elapsed_inc == MIN_W'(1));
         m2_nxt        = !at_max && (elapsed_inc == MIN_W'(2));
         m5_nxt        = !at_max && (elapsed_inc == MIN_W'(5));
      end else begin
         prescaler_nxt = prescaler + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_phase <= PH_IDLE;
         prescaler  <= '0;
         elapsed_q  <= '0;
         tick_q     <= 1'b0;
         m1_q       <= 1'b0;
         m2_q       <= 1'b0;
         m5_q       <= 1'b0;
      end else begin
         prev_phase <= phase;
         prescaler  <= prescaler_nxt;
         elapsed_q  <= elapsed_nxt;
         tick_q     <= tick_nxt;
         m1_q       <= m1_nxt;
         m2_q       <= m2_nxt;
         m5_q       <= m5_nxt;
      end
   end

   assign minute_tick = tick_q;
   assign minutes_1   = m1_q;
   assign minutes_2   = m2_q;
   assign minutes_5   = m5_q;
   assign elapsed_min = elapsed_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer: expected strobe events are queued
// as stimulus is driven and matched edge-by-edge against the outputs.
module tb_wash_phase_timer;

   localparam int BASE = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] clk_freq = 2'b00;
   logic [2:0] phase = 3'b000;
   logic       pause = 1'b0;
   logic       minute_tick;
   logic       minutes_1;
   logic       minutes_2;
   logic       minutes_5;
   logic [3:0] elapsed_min;

   wash_phase_timer #(
      .BASE_CYCLES(BASE),
      .CNT_W(32),
      .MIN_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clk_freq(clk_freq),
      .phase(phase),
      .pause(pause),
      .minute_tick(minute_tick),
      .minutes_1(minutes_1),
      .minutes_2(minutes_2),
      .minutes_5(minutes_5),
      .elapsed_min(elapsed_min)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n++;

   typedef struct {
      int         at;
      logic       tick;
      logic       m1;
      logic       m2;
      logic       m5;
      logic [3:0] el;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   bit   mon_on = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic push_min(input int at, input int k);
      exp_t e;
      e.at   = at;
      e.tick = 1'b1;
      e.m1   = (k == 1);
      e.m2   = (k == 2);
      e.m5   = (k == 5);
      e.el   = (k > 15) ? 4'd15 : 4'(k);
      q.push_back(e);
   endtask

   task automatic run_to(input int n);
      while (edge_n < n) @(negedge clk);
   endtask

   task automatic enter(input logic [2:0] ph, output int e0);
      phase = ph;
      e0 = edge_n + 1;
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (mon_on) begin
         if (q.size() > 0 && q[0].at == edge_n) begin
            e = q.pop_front();
            chk($sformatf("tick@%0d", edge_n), minute_tick, e.tick);
            chk($sformatf("m1@%0d", edge_n), minutes_1, e.m1);
            chk($sformatf("m2@%0d", edge_n), minutes_2, e.m2);
            chk($sformatf("m5@%0d", edge_n), minutes_5, e.m5);
            chk($sformatf("el@%0d", edge_n), elapsed_min, e.el);
         end else begin
            chk($sformatf("quiet@%0d", edge_n),
                {minute_tick, minutes_1, minutes_2, minutes_5}, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at edge %0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int e1;
      #2;
      chk("rst_tick", minute_tick, 0);
      chk("rst_m1", minutes_1, 0);
      chk("rst_m2", minutes_2, 0);
      chk("rst_m5", minutes_5, 0);
      chk("rst_el", elapsed_min, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      mon_on = 1'b1;
      run_to(edge_n + 3);

      // minutes at T=4, through saturation
      clk_freq = 2'b00;
      enter(3'b001, e0);
      for (int k = 1; k <= 17; k++) push_min(e0 + 4 * k, k);
      run_to(e0 + 20);
      chk("t1_el5", elapsed_min, 5);
      run_to(e0 + 69);
      chk("t1_sat", elapsed_min, 15);

      // T=32
      clk_freq = 2'b11;
      enter(3'b011, e0);
      push_min(e0 + 32, 1);
      push_min(e0 + 64, 2);
      run_to(e0 + 31);
      chk("t2_el_31", elapsed_min, 0);
      run_to(e0 + 32);
      chk("t2_el_32", elapsed_min, 1);
      run_to(e0 + 65);

      // pause for 10 edges after prescaler reaches 2
      clk_freq = 2'b00;
      enter(3'b010, e0);
      push_min(e0 + 14, 1);
      push_min(e0 + 18, 2);
      run_to(e0 + 2);
      pause = 1'b1;
      run_to(e0 + 11);
      chk("t3_el_paused", elapsed_min, 0);
      run_to(e0 + 12);
      pause = 1'b0;
      run_to(e0 + 19);

      // phase change mid-minute restarts
      enter(3'b001, e0);
      push_min(e0 + 4, 1);
      run_to(e0 + 6);
      chk("t4_el_before", elapsed_min, 1);
      enter(3'b010, e1);
      push_min(e1 + 4, 1);
      run_to(e1);
      chk("t4_el_clear", elapsed_min, 0);
      run_to(e1 + 5);

      // clk_freq drop with prescaler past the new terminal
      clk_freq = 2'b11;
      enter(3'b011, e0);
      run_to(e0 + 20);
      clk_freq = 2'b00;
      push_min(e0 + 21, 1);
      push_min(e0 + 25, 2);
      push_min(e0 + 29, 3);
      run_to(e0 + 30);

      // async reset mid-wash
      enter(3'b010, e0);
      push_min(e0 + 4, 1);
      run_to(e0 + 5);
      rst = 1'b0;
      #1;
      chk("t6_tick", minute_tick, 0);
      chk("t6_m1", minutes_1, 0);
      chk("t6_m2", minutes_2, 0);
      chk("t6_m5", minutes_5, 0);
      chk("t6_el", elapsed_min, 0);
      @(negedge clk);
      rst = 1'b1;
      e1 = edge_n + 1;
      push_min(e1 + 4, 1);
      run_to(e1 + 5);

      // idle and illegal phases never count
      enter(3'b000, e0);
      run_to(e0 + 100);
      chk("idle_el", elapsed_min, 0);
      enter(3'b110, e0);
      run_to(e0 + 12);
      chk("illegal_el", elapsed_min, 0);

      // pause asserted together with phase change
      pause = 1'b1;
      enter(3'b001, e0);
      run_to(e0 + 9);
      chk("t7_el_paused", elapsed_min, 0);
      pause = 1'b0;
      push_min(e0 + 13, 1);
      run_to(e0 + 14);

      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
